// File: rtl/inv_rotate_reader.sv
// Inverse rho rotate reader: buffers 64 rotated slices, then streams them un-rotated in z order.
// Optional ROTATE_BYPASS_EN adds a bypass input, latched on start, that emits the stored slices unrotated.
module inv_rotate_reader #(
  parameter int unsigned Z_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef ROTATE_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [24:0]       in_slice,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [24:0]       out_slice,
  output logic [Z_BITS-1:0] out_z,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LANES  = 25;
  localparam int unsigned SLICES = 1 << Z_BITS;
  localparam logic [Z_BITS-1:0] LAST_Z = Z_BITS'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  // Rho offset of lane i = x + 5y, reduced mod 2^Z_BITS
  function automatic logic [Z_BITS-1:0] rot_ofs(input int unsigned lane);
    int unsigned ofs;
    case (lane)
      0:  ofs = 0;
      1:  ofs = 1;
      2:  ofs = 62;
      3:  ofs = 28;
      4:  ofs = 27;
      5:  ofs = 36;
      6:  ofs = 44;
      7:  ofs = 6;
      8:  ofs = 55;
      9:  ofs = 20;
      10: ofs = 3;
      11: ofs = 10;
      12: ofs = 43;
      13: ofs = 25;
      14: ofs = 39;
      15: ofs = 41;
      16: ofs = 45;
      17: ofs = 15;
      18: ofs = 21;
      19: ofs = 8;
      20: ofs = 18;
      21: ofs = 2;
      22: ofs = 61;
      23: ofs = 56;
      24: ofs = 14;
      default: ofs = 0;
    endcase
    return Z_BITS'(ofs);
  endfunction

  state_e              state_q, state_d;
  logic [Z_BITS-1:0]   lc_q, lc_d;
  logic [Z_BITS-1:0]   ec_q, ec_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                wr_en;
  logic [LANES-1:0]    mem_q [SLICES];
`ifdef ROTATE_BYPASS_EN
  logic                bypass_q, bypass_d;
`endif

  // Next-state, counters and registered handshake flags
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    ec_d    = ec_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
`ifdef ROTATE_BYPASS_EN
    bypass_d = bypass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          lc_d    = '0;
`ifdef ROTATE_BYPASS_EN
          bypass_d = bypass;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          lc_d  = lc_q + 1'b1;
          if (lc_q == LAST_Z) begin
            state_d = S_EMIT;
            ec_d    = '0;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          ec_d = ec_q + 1'b1;
          if (ec_q == LAST_Z) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lc_q        <= '0;
      ec_q        <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ROTATE_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lc_q        <= lc_d;
      ec_q        <= ec_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ROTATE_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

  // Slice buffer: never reset, always fully rewritten before it is read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[lc_q] <= in_slice;
    end
  end

  // Un-rotating read: lane i of slice ec comes from stored slice ec + T[i]
  always_comb begin
    logic [Z_BITS-1:0] rd_idx;
    rd_idx    = '0;
    out_slice = '0;
    if (out_valid_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
`ifdef ROTATE_BYPASS_EN
        rd_idx = bypass_q ? ec_q : ec_q + rot_ofs(i);
`else
        rd_idx = ec_q + rot_ofs(i);
`endif
        out_slice[i] = mem_q[rd_idx][i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_valid_q ? ec_q : '0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
